// File: rtl/mips_run_monitor_pkg.sv
// mips_run_monitor_pkg: shared types and helpers for the mips_cpu_harvard run
// monitor. Holds the run-tracking state enum, the trace entry record and the
// saturating increment used by the cycle counter.
package mips_run_monitor_pkg;

    // Lifecycle of one program run, from reset release to a terminal state.
    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE,
        TIMEOUT
    } run_state_t;

    // One captured data-memory write.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } trace_entry_t;

    localparam logic [31:0] CYCLE_MAX = 32'hFFFF_FFFF;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == CYCLE_MAX) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/mips_run_monitor_fifo.sv
// mips_run_monitor_fifo: synchronous show-ahead FIFO of trace entries.
// A pop of an empty FIFO is ignored; a push into a full FIFO is dropped and
// sets the sticky overflow flag unless a pop frees the slot on the same edge.
// DEPTH must be a power of two so the pointers wrap naturally.
module mips_run_monitor_fifo
    import mips_run_monitor_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  trace_entry_t               i_entry,
    input  logic                       i_pop,
    output trace_entry_t               o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    trace_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == FULL_COUNT);
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !w_empty;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    // Storage write at the tail slot.
    // NOTE: the entry array has no reset; an empty FIFO never exposes a slot,
    // so clearing it would only cost reset fan-out.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    // Pointer, occupancy and sticky overflow bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (i_push && !w_do_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Head is presented combinationally and forced to zero when empty.
    assign o_head     = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/mips_cpu_run_monitor.sv
// mips_cpu_run_monitor: follows one mips_cpu_harvard program run from reset
// release to halt. Counts RUN cycles, enforces TIMEOUT_CYCLES, records the
// last fetch address and captures $v0 one settling cycle after halt.
// Define MIPS_RUN_MONITOR_TRACE_EN to build the data-write trace FIFO; without
// it the trace outputs are tied to zero and trace_pop is ignored.
module mips_cpu_run_monitor
    import mips_run_monitor_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100,
    parameter int TRACE_DEPTH    = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           active,
    input  logic [31:0]                    register_v0,
    input  logic [31:0]                    instr_address,
    input  logic                           data_write,
    input  logic [31:0]                    data_address,
    input  logic [31:0]                    data_writedata,
    input  logic                           trace_pop,
    output logic                           done,
    output logic                           timeout,
    output logic [31:0]                    cycle_count,
    output logic [31:0]                    result_v0,
    output logic [31:0]                    last_pc,
    output logic                           trace_valid,
    output logic [31:0]                    trace_addr,
    output logic [31:0]                    trace_data,
    output logic [$clog2(TRACE_DEPTH):0]   trace_count,
    output logic                           trace_overflow
);
    // A counted cycle whose pre-edge count equals this value reaches the limit.
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    run_state_t  r_state;
    run_state_t  w_state_next;
    logic        w_count_en;
    logic        w_timeout_hit;
    logic [31:0] r_cycle_count;
    logic [31:0] r_result_v0;
    logic [31:0] r_last_pc;

    assign w_timeout_hit = (r_cycle_count >= TIMEOUT_LAST);

    // Next-state and cycle-accounting decode.
    // NOTE: every output of this block is given a default first so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_count_en   = 1'b0;
        case (r_state)
            IDLE: begin
                if (active) begin
                    // The entry cycle is itself a counted RUN cycle.
                    w_count_en   = 1'b1;
                    w_state_next = (TIMEOUT_LAST == 32'd0) ? TIMEOUT : RUN;
                end
            end
            RUN: begin
                // Reaching the limit wins over a simultaneous halt.
                if (w_timeout_hit) begin
                    w_count_en   = 1'b1;
                    w_state_next = TIMEOUT;
                end else if (!active) begin
                    w_state_next = DRAIN;
                end else begin
                    w_count_en   = 1'b1;
                end
            end
            DRAIN: begin
                w_state_next = DONE;
            end
            default: begin
                // DONE and TIMEOUT are held until reset.
                w_state_next = r_state;
            end
        endcase
    end

    // State register, cycle counter, last fetch address and result capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_cycle_count <= '0;
            r_result_v0   <= '0;
            r_last_pc     <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_count_en) begin
                r_cycle_count <= sat_inc(r_cycle_count);
                r_last_pc     <= instr_address;
            end
            // The DRAIN cycle lets $v0 settle after the CPU drops active.
            if (r_state == DRAIN) begin
                r_result_v0 <= register_v0;
            end
        end
    end

    assign done        = (r_state == DONE);
    assign timeout     = (r_state == TIMEOUT);
    assign cycle_count = r_cycle_count;
    assign result_v0   = r_result_v0;
    assign last_pc     = r_last_pc;

`ifdef MIPS_RUN_MONITOR_TRACE_EN
    logic         w_trace_push;
    trace_entry_t w_push_entry;
    trace_entry_t w_head;
    logic         w_fifo_full;
    logic         w_fifo_empty;

    // Only writes made while the program is running or draining are traced.
    assign w_trace_push      = data_write && ((r_state == RUN) || (r_state == DRAIN));
    assign w_push_entry.addr = data_address;
    assign w_push_entry.data = data_writedata;

    mips_run_monitor_fifo #(
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .i_clk      (clk),
        .i_rst_n    (reset),
        .i_push     (w_trace_push),
        .i_entry    (w_push_entry),
        .i_pop      (trace_pop),
        .o_head     (w_head),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_count    (trace_count),
        .o_overflow (trace_overflow)
    );

    assign trace_valid = !w_fifo_empty;
    assign trace_addr  = w_head.addr;
    assign trace_data  = w_head.data;

    logic w_unused_trace;
    assign w_unused_trace = w_fifo_full;
`else
    // Trace path not built: inputs are consumed only to keep them declared.
    logic w_unused_trace;
    assign w_unused_trace = ^{trace_pop, data_write, data_address, data_writedata};

    assign trace_valid    = 1'b0;
    assign trace_addr     = '0;
    assign trace_data     = '0;
    assign trace_count    = '0;
    assign trace_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_mips_cpu_run_monitor.sv
// tb_mips_cpu_run_monitor: self-checking bench for mips_cpu_run_monitor with
// TIMEOUT_CYCLES=10 and TRACE_DEPTH=4. A behavioural run/trace model checks
// every output on each falling clock edge; directed scenarios add literal
// expectations. Trace expectations follow MIPS_RUN_MONITOR_TRACE_EN.
`timescale 1ns/1ps
module tb_mips_cpu_run_monitor;
    localparam int TO = 10;
    localparam int TD = 4;
`ifdef MIPS_RUN_MONITOR_TRACE_EN
    localparam bit TRACE_EN = 1'b1;
`else
    localparam bit TRACE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        active = 1'b0;
    logic [31:0] register_v0 = '0;
    logic [31:0] instr_address = '0;
    logic        data_write = 1'b0;
    logic [31:0] data_address = '0;
    logic [31:0] data_writedata = '0;
    logic        trace_pop = 1'b0;
    logic        done;
    logic        timeout;
    logic [31:0] cycle_count;
    logic [31:0] result_v0;
    logic [31:0] last_pc;
    logic        trace_valid;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;
    logic [$clog2(TD):0] trace_count;
    logic        trace_overflow;

    int n_checks = 0;
    int n_err    = 0;

    mips_cpu_run_monitor #(
        .TIMEOUT_CYCLES (TO),
        .TRACE_DEPTH    (TD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .active         (active),
        .register_v0    (register_v0),
        .instr_address  (instr_address),
        .data_write     (data_write),
        .data_address   (data_address),
        .data_writedata (data_writedata),
        .trace_pop      (trace_pop),
        .done           (done),
        .timeout        (timeout),
        .cycle_count    (cycle_count),
        .result_v0      (result_v0),
        .last_pc        (last_pc),
        .trace_valid    (trace_valid),
        .trace_addr     (trace_addr),
        .trace_data     (trace_data),
        .trace_count    (trace_count),
        .trace_overflow (trace_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Trace expectations collapse to zero when the trace path is not built.
    function automatic logic [31:0] te(input logic [31:0] v);
        return TRACE_EN ? v : 32'd0;
    endfunction

    // ---------------- behavioural model ----------------
    localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3, P_TO = 4;
    int          m_phase = P_IDLE;
    logic [31:0] m_count = '0;
    logic [31:0] m_pc    = '0;
    logic [31:0] m_v0    = '0;
    bit          m_ovf   = 1'b0;
    logic [63:0] m_q[$];
    bit          m_counted;
    bit          m_push;
    bit          m_pop;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase = P_IDLE;
            m_count = '0;
            m_pc    = '0;
            m_v0    = '0;
            m_ovf   = 1'b0;
            m_q.delete();
        end else begin
            m_push    = data_write && (m_phase == P_RUN || m_phase == P_DRAIN);
            m_pop     = trace_pop && (m_q.size() > 0);
            m_counted = 1'b0;
            if (m_phase == P_IDLE && active) begin
                m_counted = 1'b1;
                m_phase   = (TO <= 1) ? P_TO : P_RUN;
            end else if (m_phase == P_RUN) begin
                if (longint'(m_count) + 1 >= TO) begin
                    m_counted = 1'b1;
                    m_phase   = P_TO;
                end else if (!active) begin
                    m_phase = P_DRAIN;
                end else begin
                    m_counted = 1'b1;
                end
            end else if (m_phase == P_DRAIN) begin
                m_v0    = register_v0;
                m_phase = P_DONE;
            end
            if (m_counted) begin
                if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
                m_pc = instr_address;
            end
            if (m_pop) void'(m_q.pop_front());
            if (m_push) begin
                if (m_q.size() < TD) m_q.push_back({data_address, data_writedata});
                else m_ovf = 1'b1;
            end
        end
    end

    task automatic compare_all();
        logic [63:0] head;
        bit          vld;
        vld  = TRACE_EN && (m_q.size() != 0);
        head = vld ? m_q[0] : 64'd0;
        check("done",           done,           m_phase == P_DONE);
        check("timeout",        timeout,        m_phase == P_TO);
        check("cycle_count",    cycle_count,    m_count);
        check("result_v0",      result_v0,      m_v0);
        check("last_pc",        last_pc,        m_pc);
        check("trace_valid",    trace_valid,    vld);
        check("trace_addr",     trace_addr,     head[63:32]);
        check("trace_data",     trace_data,     head[31:0]);
        check("trace_count",    trace_count,    TRACE_EN ? m_q.size() : 0);
        check("trace_overflow", trace_overflow, TRACE_EN && m_ovf);
    endtask

    always @(negedge clk) compare_all();

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input bit a, input bit we, input logic [31:0] ad,
                       input logic [31:0] wd, input bit pp);
        active = a; data_write = we; data_address = ad; data_writedata = wd; trace_pop = pp;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        active = 1'b0; data_write = 1'b0; trace_pop = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " done"},        done,           0);
        check({tag, " timeout"},     timeout,        0);
        check({tag, " cycle_count"}, cycle_count,    0);
        check({tag, " result_v0"},   result_v0,      0);
        check({tag, " last_pc"},     last_pc,        0);
        check({tag, " trace_valid"}, trace_valid,    0);
        check({tag, " trace_count"}, trace_count,    0);
        check({tag, " trace_ovf"},   trace_overflow, 0);
        check({tag, " trace_addr"},  trace_addr,     0);
        check({tag, " trace_data"},  trace_data,     0);
    endtask

    initial begin
        // Reset, then idle with active low.
        #1 reset = 1'b0;
        #2 check_all_zero("reset");
        @(posedge clk); #2;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0);
        check("idle done", done, 0);
        check("idle cycle_count", cycle_count, 0);

        // Seven-cycle run with three traced writes, then halt.
        register_v0 = 32'h0000_002A;
        instr_address = 32'h0040_0000;
        cyc(1, 0, 0, 0, 0);
        instr_address = 32'h0040_0004; cyc(1, 1, 32'h10, 32'hA, 0);
        instr_address = 32'h0040_0008; cyc(1, 1, 32'h14, 32'hB, 0);
        instr_address = 32'h0040_000C; cyc(1, 1, 32'h18, 32'hC, 0);
        instr_address = 32'h0040_0010; cyc(1, 0, 0, 0, 0);
        instr_address = 32'h0040_0014; cyc(1, 0, 0, 0, 0);
        instr_address = 32'h0040_0018; cyc(1, 0, 0, 0, 0);
        instr_address = 32'hDEAD_BEEF;
        cyc(0, 0, 0, 0, 0);
        check("drain done", done, 0);
        cyc(0, 0, 0, 0, 0);
        check("run done", done, 1);
        check("run cycle_count", cycle_count, 7);
        check("run result_v0", result_v0, 42);
        check("run timeout", timeout, 0);
        check("run last_pc", last_pc, 32'h0040_0018);
        check("run trace_count", trace_count, te(3));
        check("head0 addr", trace_addr, te(32'h10));
        check("head0 data", trace_data, te(32'hA));
        cyc(0, 0, 0, 0, 1);
        check("head1 addr", trace_addr, te(32'h14));
        check("head1 data", trace_data, te(32'hB));
        check("pop1 count", trace_count, te(2));
        cyc(0, 0, 0, 0, 1);
        check("head2 addr", trace_addr, te(32'h18));
        check("head2 data", trace_data, te(32'hC));
        cyc(0, 0, 0, 0, 1);
        check("drained valid", trace_valid, 0);
        check("drained count", trace_count, 0);

        // Timeout run with an overflowing trace.
        do_reset();
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 1, 32'h20 + 32'(4 * i), 32'h100 + 32'(i), 0);
        check("full count", trace_count, te(4));
        check("overflow", trace_overflow, te(1));
        check("full head", trace_addr, te(32'h20));
        cyc(1, 1, 32'h40, 32'h99, 1);
        check("push+pop count", trace_count, te(4));
        check("push+pop head", trace_addr, te(32'h24));
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check("pre-timeout", timeout, 0);
        check("pre-timeout count", cycle_count, 9);
        cyc(1, 0, 0, 0, 0);
        check("timeout", timeout, 1);
        check("timeout count", cycle_count, 10);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0);
        check("frozen count", cycle_count, 10);
        check("no done", done, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        check("tail-1 head", trace_addr, te(32'h2C));
        cyc(0, 0, 0, 0, 1);
        check("tail addr", trace_addr, te(32'h40));
        check("tail data", trace_data, te(32'h99));

        // Asynchronous reset in the middle of a run with entries held.
        do_reset();
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 32'h50, 32'h1, 0);
        cyc(1, 1, 32'h54, 32'h2, 0);
        check("held count", trace_count, te(2));
        #1 reset = 1'b0;
        #1 check_all_zero("async");
        @(posedge clk); #2;
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0);
        check("post-reset count", trace_count, 0);
        check("post-reset valid", trace_valid, 0);

        // Randomised short runs checked against the model.
        for (int t = 0; t < 25; t++) begin
            int idle_n, run_n;
            do_reset();
            idle_n = $urandom_range(0, 3);
            run_n  = $urandom_range(1, 8);
            for (int i = 0; i < idle_n; i++) begin
                instr_address = $urandom;
                cyc(0, $urandom_range(0, 1) == 1, $urandom, $urandom, $urandom_range(0, 1) == 1);
            end
            for (int i = 0; i < run_n; i++) begin
                instr_address = $urandom;
                register_v0   = $urandom;
                cyc(1, $urandom_range(0, 1) == 1, $urandom, $urandom, $urandom_range(0, 3) == 0);
            end
            for (int i = 0; i < 3; i++) begin
                register_v0 = $urandom;
                cyc(0, $urandom_range(0, 1) == 1, $urandom, $urandom, $urandom_range(0, 3) == 0);
            end
            for (int i = 0; i < 5; i++) begin
                cyc($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom, $urandom, 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
